// File: rtl/alu_decode_stage.sv
// alu_decode_stage
// ----------------
// Decode/issue stage in front of the 3-bit-opcode ALU. Raw RV32I words plus
// their register-file operands arrive over a valid/ready handshake, the
// ALU-class subset (R-type, I-type arithmetic/logic/shift, BEQ/BNE) is decoded
// into an operation and two operands, and the result leaves through a
// registered two-entry skid buffer toward the execute stage.
//
// Ports:
//   clk, rst            clock (rising edge) and async active-high reset
//   in_valid/in_ready   input handshake; in_ready is registered (!skid full)
//   instr               RV32I instruction word
//   rs1_data/rs2_data   register-file values for instr[19:15] / instr[24:20]
//   out_valid/out_ready output handshake toward execute
//   alu_op, alu_a/b     ALU operation and operands
//   rd, reg_write       destination register and write-back enable
//   is_branch, br_ne    BEQ/BNE marker and polarity (1 = BNE)
//   illegal             instruction outside the supported subset
//   illegal_count       saturating count of accepted illegal instructions

module alu_decode_stage #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [31:0]      rs1_data,
   input  logic [31:0]      rs2_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [2:0]       alu_op,
   output logic [31:0]      alu_a,
   output logic [31:0]      alu_b,
   output logic [4:0]       rd,
   output logic             reg_write,
   output logic             is_branch,
   output logic             br_ne,
   output logic             illegal,
   output logic [CNT_W-1:0] illegal_count
);

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SLL = 3'b001,
      ALU_SUB = 3'b010,
      ALU_SRL = 3'b011,
      ALU_XOR = 3'b100,
      ALU_AND = 3'b110,
      ALU_OR  = 3'b111
   } aluOpT;

   typedef struct packed {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        regWrite;
      logic        isBranch;
      logic        brNe;
      logic        illegal;
   } bundleT;

   localparam logic [6:0] OPC_R   = 7'b0110011;
   localparam logic [6:0] OPC_I   = 7'b0010011;
   localparam logic [6:0] OPC_BR  = 7'b1100011;
   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] immI;
   logic [31:0] shamt;
   logic        legal;
   bundleT      decBundle;
   bundleT      mainBundle;
   bundleT      skidBundle;
   logic        mainValid;
   logic        skidValid;
   logic        inXfer;
   logic        unusedRs1Field;

   assign opcode = instr[6:0];
   assign funct3 = instr[14:12];
   assign funct7 = instr[31:25];
   assign immI   = {{20{instr[31]}}, instr[31:20]};
   assign shamt  = {27'b0, instr[24:20]};

   // The rs1 index field is already resolved by the register file upstream.
   assign unusedRs1Field = ^instr[19:15];

   assign inXfer = in_valid & in_ready;

   // Combinational decode of the incoming word. Each opcode group fills in
   // operands and marks itself legal; any unsupported encoding falls back to
   // a harmless ADD 0,0 with no write-back so it can still flow downstream.
   always_comb begin
      decBundle = '0;
      legal     = 1'b0;
      case (opcode)
         OPC_R: begin
            decBundle.a  = rs1_data;
            decBundle.b  = rs2_data;
            decBundle.rd = instr[11:7];
            legal        = (funct7 == F7_ZERO);
            case (funct3)
               3'b000: begin
                  decBundle.op = (funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
                  legal        = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
               end
               3'b001:  decBundle.op = ALU_SLL;
               3'b100:  decBundle.op = ALU_XOR;
               3'b101:  decBundle.op = ALU_SRL;
               3'b110:  decBundle.op = ALU_OR;
               3'b111:  decBundle.op = ALU_AND;
               default: legal = 1'b0;
            endcase
         end
         OPC_I: begin
            decBundle.a  = rs1_data;
            decBundle.b  = immI;
            decBundle.rd = instr[11:7];
            legal        = 1'b1;
            case (funct3)
               3'b000:  decBundle.op = ALU_ADD;
               3'b100:  decBundle.op = ALU_XOR;
               3'b110:  decBundle.op = ALU_OR;
               3'b111:  decBundle.op = ALU_AND;
               3'b001: begin
                  decBundle.op = ALU_SLL;
                  decBundle.b  = shamt;
                  legal        = (funct7 == F7_ZERO);
               end
               3'b101: begin
                  decBundle.op = ALU_SRL;
                  decBundle.b  = shamt;
                  legal        = (funct7 == F7_ZERO);
               end
               default: legal = 1'b0;
            endcase
         end
         OPC_BR: begin
            decBundle.op       = ALU_SUB;
            decBundle.a        = rs1_data;
            decBundle.b        = rs2_data;
            decBundle.isBranch = 1'b1;
            decBundle.brNe     = (funct3 == 3'b001);
            legal              = (funct3 == 3'b000) || (funct3 == 3'b001);
         end
         default: legal = 1'b0;
      endcase

      if (!legal) begin
         decBundle = '0;
      end
      decBundle.illegal  = !legal;
      decBundle.regWrite = legal && !decBundle.isBranch && (decBundle.rd != 5'd0);
   end

   // Two-entry skid buffer. Main feeds the outputs; skid catches the bundle
   // accepted in the same cycle that main is stalled. Because in_ready is just
   // !skidValid, a full skid always has priority when main frees up, which
   // keeps the stream in order without any combinational path from out_ready.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mainBundle <= '0;
         skidBundle <= '0;
         mainValid  <= 1'b0;
         skidValid  <= 1'b0;
      end else if (!mainValid || out_ready) begin
         if (skidValid) begin
            mainBundle <= skidBundle;
            mainValid  <= 1'b1;
            skidValid  <= 1'b0;
         end else if (inXfer) begin
            mainBundle <= decBundle;
            mainValid  <= 1'b1;
         end else begin
            mainValid  <= 1'b0;
         end
      end else if (inXfer) begin
         skidBundle <= decBundle;
         skidValid  <= 1'b1;
      end
   end

   // Count accepted illegal words, sticking at the top value instead of
   // wrapping so software can tell "many" from "few".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal_count <= '0;
      end else if (inXfer && decBundle.illegal && (illegal_count != CNT_MAX)) begin
         illegal_count <= illegal_count + 1'b1;
      end
   end

   assign in_ready  = !skidValid;
   assign out_valid = mainValid;
   assign alu_op    = mainBundle.op;
   assign alu_a     = mainBundle.a;
   assign alu_b     = mainBundle.b;
   assign rd        = mainBundle.rd;
   assign reg_write = mainBundle.regWrite;
   assign is_branch = mainBundle.isBranch;
   assign br_ne     = mainBundle.brNe;
   assign illegal   = mainBundle.illegal;

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb_alu_decode_stage
// -------------------
// Directed bench for alu_decode_stage: decode of representative R/I/branch
// words, illegal handling and counter saturation, skid-buffer ordering under
// back-pressure, and asynchronous reset with both buffer entries occupied.

module tb_alu_decode_stage;

   logic        clk;
   logic        rst;
   logic        inValid;
   logic        inReady;
   logic [31:0] instr;
   logic [31:0] rs1Data;
   logic [31:0] rs2Data;
   logic        outValid;
   logic        outReady;
   logic [2:0]  aluOp;
   logic [31:0] aluA;
   logic [31:0] aluB;
   logic [4:0]  rd;
   logic        regWrite;
   logic        isBranch;
   logic        brNe;
   logic        illegal;
   logic [7:0]  illegalCount;

   int total;
   int bad;

   alu_decode_stage #(.CNT_W(8)) dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (inValid),
      .in_ready     (inReady),
      .instr        (instr),
      .rs1_data     (rs1Data),
      .rs2_data     (rs2Data),
      .out_valid    (outValid),
      .out_ready    (outReady),
      .alu_op       (aluOp),
      .alu_a        (aluA),
      .alu_b        (aluB),
      .rd           (rd),
      .reg_write    (regWrite),
      .is_branch    (isBranch),
      .br_ne        (brNe),
      .illegal      (illegal),
      .illegal_count(illegalCount)
   );

   // Free-running 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rType(input logic [6:0] f7, input logic [4:0] r2,
                                         input logic [4:0] r1, input logic [2:0] f3,
                                         input logic [4:0] d);
      return {f7, r2, r1, f3, d, 7'b0110011};
   endfunction

   function automatic logic [31:0] iType(input logic [11:0] imm, input logic [4:0] r1,
                                         input logic [2:0] f3, input logic [4:0] d);
      return {imm, r1, f3, d, 7'b0010011};
   endfunction

   function automatic logic [31:0] bType(input logic [2:0] f3, input logic [4:0] r1,
                                         input logic [4:0] r2);
      return {7'b0, r2, r1, f3, 5'b0, 7'b1100011};
   endfunction

   // Drive one cycle of inputs on the falling edge, then let the rising edge
   // happen and settle 1 unit past it so outputs can be sampled.
   task automatic applyStimulus(input logic v, input logic [31:0] ins,
                                input logic [31:0] a, input logic [31:0] b,
                                input logic ordy);
      @(negedge clk);
      inValid  = v;
      instr    = ins;
      rs1Data  = a;
      rs2Data  = b;
      outReady = ordy;
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      rst      = 1'b1;
      inValid  = 1'b0;
      instr    = 32'h0;
      rs1Data  = 32'h0;
      rs2Data  = 32'h0;
      outReady = 1'b1;

      #2;
      checkOutput("reset out_valid", {31'b0, outValid}, 32'd0);
      checkOutput("reset in_ready", {31'b0, inReady}, 32'd1);
      checkOutput("reset count", {24'b0, illegalCount}, 32'd0);
      checkOutput("reset alu_a", aluA, 32'd0);
      @(negedge clk);
      rst = 1'b0;

      // ADD x3,x1,x2
      applyStimulus(1'b1, rType(7'b0, 5'd2, 5'd1, 3'b000, 5'd3), 32'd5, 32'd7, 1'b1);
      checkOutput("add valid", {31'b0, outValid}, 32'd1);
      checkOutput("add op", {29'b0, aluOp}, 32'd0);
      checkOutput("add a", aluA, 32'd5);
      checkOutput("add b", aluB, 32'd7);
      checkOutput("add rd", {27'b0, rd}, 32'd3);
      checkOutput("add wr", {31'b0, regWrite}, 32'd1);
      checkOutput("add illegal", {31'b0, illegal}, 32'd0);

      // ADDI x4,x1,-1
      applyStimulus(1'b1, iType(12'hFFF, 5'd1, 3'b000, 5'd4), 32'd10, 32'd99, 1'b1);
      checkOutput("addi op", {29'b0, aluOp}, 32'd0);
      checkOutput("addi a", aluA, 32'd10);
      checkOutput("addi b", aluB, 32'hFFFF_FFFF);
      checkOutput("addi rd", {27'b0, rd}, 32'd4);

      // SRLI x5,x1,31
      applyStimulus(1'b1, iType(12'h01F, 5'd1, 3'b101, 5'd5), 32'h8000_0000, 32'd0, 1'b1);
      checkOutput("srli op", {29'b0, aluOp}, 32'd3);
      checkOutput("srli b", aluB, 32'd31);

      // OR x6,x1,x2
      applyStimulus(1'b1, rType(7'b0, 5'd2, 5'd1, 3'b110, 5'd6), 32'hF0, 32'h0F, 1'b1);
      checkOutput("or op", {29'b0, aluOp}, 32'd7);
      checkOutput("or b", aluB, 32'h0F);

      // SUB x7,x1,x2
      applyStimulus(1'b1, rType(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd7), 32'd9, 32'd4, 1'b1);
      checkOutput("sub op", {29'b0, aluOp}, 32'd2);

      // BNE x1,x2 with equal operands
      applyStimulus(1'b1, bType(3'b001, 5'd1, 5'd2), 32'd9, 32'd9, 1'b1);
      checkOutput("bne op", {29'b0, aluOp}, 32'd2);
      checkOutput("bne branch", {31'b0, isBranch}, 32'd1);
      checkOutput("bne ne", {31'b0, brNe}, 32'd1);
      checkOutput("bne wr", {31'b0, regWrite}, 32'd0);
      checkOutput("bne a", aluA, 32'd9);

      // ADD x0,x1,x2 must not write back
      applyStimulus(1'b1, rType(7'b0, 5'd2, 5'd1, 3'b000, 5'd0), 32'd1, 32'd2, 1'b1);
      checkOutput("add x0 wr", {31'b0, regWrite}, 32'd0);
      checkOutput("add x0 illegal", {31'b0, illegal}, 32'd0);

      // SRA is outside the subset
      applyStimulus(1'b1, rType(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd8), 32'd5, 32'd7, 1'b1);
      checkOutput("sra illegal", {31'b0, illegal}, 32'd1);
      checkOutput("sra a", aluA, 32'd0);
      checkOutput("sra b", aluB, 32'd0);
      checkOutput("sra wr", {31'b0, regWrite}, 32'd0);
      checkOutput("sra count", {24'b0, illegalCount}, 32'd1);

      // SLT
      applyStimulus(1'b1, rType(7'b0, 5'd2, 5'd1, 3'b010, 5'd8), 32'd5, 32'd7, 1'b1);
      checkOutput("slt illegal", {31'b0, illegal}, 32'd1);
      checkOutput("slt op", {29'b0, aluOp}, 32'd0);

      // Load opcode
      applyStimulus(1'b1, 32'h0000_A183, 32'd5, 32'd7, 1'b1);
      checkOutput("load illegal", {31'b0, illegal}, 32'd1);
      checkOutput("load b", aluB, 32'd0);
      checkOutput("load count", {24'b0, illegalCount}, 32'd3);

      // Counter climbs then saturates at 255
      for (int i = 0; i < 100; i++) begin
         applyStimulus(1'b1, 32'h0000_A183, 32'd1, 32'd2, 1'b1);
      end
      checkOutput("count 103", {24'b0, illegalCount}, 32'd103);
      for (int i = 0; i < 200; i++) begin
         applyStimulus(1'b1, 32'h0000_A183, 32'd1, 32'd2, 1'b1);
      end
      checkOutput("count sat", {24'b0, illegalCount}, 32'd255);

      // Drain, then stream I0..I3 (ADDI with immediates 100..103, rs1 = 0)
      applyStimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
      checkOutput("drained", {31'b0, outValid}, 32'd0);
      applyStimulus(1'b1, iType(12'd100, 5'd1, 3'b000, 5'd9), 32'd0, 32'd0, 1'b1);
      checkOutput("I0 issued", aluB, 32'd100);
      applyStimulus(1'b1, iType(12'd101, 5'd1, 3'b000, 5'd9), 32'd0, 32'd0, 1'b0);
      checkOutput("I0 held", aluB, 32'd100);
      checkOutput("skid ready low", {31'b0, inReady}, 32'd0);
      applyStimulus(1'b1, iType(12'd102, 5'd1, 3'b000, 5'd9), 32'd0, 32'd0, 1'b0);
      checkOutput("I0 still held", aluB, 32'd100);
      checkOutput("still not ready", {31'b0, inReady}, 32'd0);
      applyStimulus(1'b1, iType(12'd102, 5'd1, 3'b000, 5'd9), 32'd0, 32'd0, 1'b1);
      checkOutput("I1 issued", aluB, 32'd101);
      checkOutput("ready again", {31'b0, inReady}, 32'd1);
      applyStimulus(1'b1, iType(12'd102, 5'd1, 3'b000, 5'd9), 32'd0, 32'd0, 1'b1);
      checkOutput("I2 issued", aluB, 32'd102);
      applyStimulus(1'b1, iType(12'd103, 5'd1, 3'b000, 5'd9), 32'd0, 32'd0, 1'b1);
      checkOutput("I3 issued", aluB, 32'd103);
      checkOutput("I3 valid", {31'b0, outValid}, 32'd1);
      applyStimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
      checkOutput("stream end", {31'b0, outValid}, 32'd0);

      // Fill both entries, then reset asynchronously between edges
      applyStimulus(1'b1, iType(12'd200, 5'd1, 3'b000, 5'd9), 32'd0, 32'd0, 1'b1);
      applyStimulus(1'b1, 32'h0000_A183, 32'd0, 32'd0, 1'b0);
      applyStimulus(1'b1, 32'h0000_A183, 32'd0, 32'd0, 1'b0);
      checkOutput("full not ready", {31'b0, inReady}, 32'd0);
      checkOutput("full main", aluB, 32'd200);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("async valid", {31'b0, outValid}, 32'd0);
      checkOutput("async ready", {31'b0, inReady}, 32'd1);
      checkOutput("async count", {24'b0, illegalCount}, 32'd0);
      checkOutput("async b", aluB, 32'd0);
      @(negedge clk);
      inValid  = 1'b0;
      outReady = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
      checkOutput("post reset 1", {31'b0, outValid}, 32'd0);
      applyStimulus(1'b0, 32'h0, 32'd0, 32'd0, 1'b1);
      checkOutput("post reset 2", {31'b0, outValid}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Decode/issue stage that produces the operand and control bundle consumed by the core's 3-bit-opcode ALU. It accepts raw RV32I instructions plus register-file read data over a valid/ready handshake, decodes the ALU-class subset into `alu_op`/`alu_a`/`alu_b`, and presents the result through a registered two-entry skid buffer. The buffer gives one-cycle latency and full throughput toward the execute stage.

## Interface
Parameters:
- `CNT_W`, default 8: width of the illegal-instruction counter.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  instruction bundle valid.
- `in_ready`  out  1  stage can accept; equals NOT skid_valid.
- `instr`  in  32  RV32I instruction word.
- `rs1_data`  in  32  register-file value for instr[19:15].
- `rs2_data`  in  32  register-file value for instr[24:20].
- `out_valid`  out  1  issue bundle valid.
- `out_ready`  in  1  execute stage accepts.
- `alu_op`  out  3  ADD 000, SLL 001, SUB 010, SRL 011, XOR 100, AND 110, OR 111.
- `alu_a`, `alu_b`  out  32  ALU operands.
- `rd`  out  5  destination register.
- `reg_write`  out  1  result is written back.
- `is_branch`  out  1  BEQ/BNE; execute uses ALU Zero.
- `br_ne`  out  1  1 = BNE (take on Zero=0), 0 = BEQ.
- `illegal`  out  1  instruction outside the supported subset.
- `illegal_count`  out  CNT_W  saturating count of accepted illegal instructions.

## Operation
- Decode is combinational on `instr`; the result is captured on input transfer (in_valid & in_ready).
- Opcode 0110011 (R-type), with operands A=rs1_data, B=rs2_data:
  - f3 000 + f7 0000000 → ADD; f3 000 + f7 0100000 → SUB.
  - f3 001 + f7 0 → SLL; f3 100 + f7 0 → XOR; f3 101 + f7 0 → SRL.
  - f3 110 + f7 0 → OR; f3 111 + f7 0 → AND.
  - All other f3/f7 combinations are illegal (SLT, SLTU, SRA, ...).
- Opcode 0010011 (I-type), with A=rs1_data:
  - f3 000/100/110/111 → ADD/XOR/OR/AND, B = sign-extended instr[31:20].
  - f3 001 + f7 0 → SLL; f3 101 + f7 0 → SRL; for both, B = {27'b0, instr[24:20]}.
  - Everything else is illegal.
- Opcode 1100011: f3 000 → BEQ, f3 001 → BNE.
  - alu_op = SUB, A = rs1_data, B = rs2_data, is_branch = 1, reg_write = 0.
  - Other f3 values are illegal.
- Any other opcode is illegal.
- Legal R/I-type: reg_write = 1 unless rd == 0.
- Illegal instructions still flow through with: alu_op = ADD, alu_a = alu_b = 0, reg_write = 0, is_branch = 0, illegal = 1.
- `illegal_count` increments on each input transfer flagged illegal and saturates at 2^CNT_W - 1.

Skid buffer, with entries main (drives the outputs) and skid:
- Main empty or draining (out_ready) → the incoming bundle loads main.
- Main holding (out_valid & !out_ready) → the incoming bundle loads skid; in_ready drops next cycle.
- Main drains while skid is full → skid moves to main, skid empties, and in_ready rises next cycle.
- Strict FIFO order; no bundle is dropped or duplicated.
- Output fields are stable while out_valid & !out_ready.

## Timing
- Latency: an input transfer at edge N gives out_valid = 1 after edge N with that bundle.
- Throughput: 1 bundle per cycle while out_ready is held high.
- in_ready is registered (derived from skid_valid only) and never depends combinationally on out_ready.
- Reset (async, immediate), with all values holding until the first clk edge after rst deasserts:
  - out_valid = 0, skid empty, in_ready = 1.
  - All data outputs = 0.
  - illegal_count = 0.
- Reset mid-operation discards both entries; nothing is issued after deassertion until a new transfer.
- Simultaneous input transfer and output drain with skid empty → main reloads with no bubble.
- in_valid while in_ready = 0 → ignored, counter unchanged.

## Test plan
- ADD x3,x1,x2 with rs1 = 5, rs2 = 7, out_ready = 1 → next cycle out_valid = 1, alu_op = 000, A = 5, B = 7, rd = 3, reg_write = 1.
- ADDI x4,x1,-1 (imm 0xFFF) → alu_b = 0xFFFFFFFF. SRLI shamt 31 → alu_op = 011, alu_b = 31. OR R-type → alu_op = 111.
- BNE rs1 = rs2 = 9 → alu_op = 010, is_branch = 1, br_ne = 1, reg_write = 0. ADD into rd = 0 → reg_write = 0.
- SRA, SLT, and opcode 0000011 → illegal = 1, A = B = 0; 300 illegal transfers with CNT_W = 8 → illegal_count = 255.
- Back-to-back stream of I0..I3 with out_ready low for 2 cycles after I0 issues:
  - in_ready falls after I1 is skidded; I2 is held at the input.
  - Output order I0, I1, I2, I3 with no loss and no duplication.
  - Full rate resumes once out_ready returns high.
- rst asserted asynchronously between clock edges with both entries full → out_valid = 0 and in_ready = 1 immediately, illegal_count = 0, no stale output after release.
